// File: rtl/nn_layer_sequencer_pkg.sv
// Shared types and constants for the fully-connected layer sequencer.
// Holds the FSM state encoding, default layer geometry and a width helper.
package nn_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_ACT   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam int DEF_N_IN    = 4;
  localparam int DEF_N_OUT   = 4;
  localparam int DEF_MAC_LAT = 1;

  // Ceiling log2, never below 1 so a degenerate counter still has a bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nn_index_counter.sv
// Terminal-count index counter: clears, increments, and wraps to 0 after max.
// Used for the input index, the neuron index and the drain delay.
module nn_index_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign last = (cnt_q == max);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Sequences one fully-connected layer through the shared MAC datapath:
// per neuron it clears, streams N_IN operand addresses, drains, activates, writes.
module nn_layer_sequencer
  import nn_layer_sequencer_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int N_OUT   = DEF_N_OUT,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int IN_AW   = 2,
  parameter int W_AW    = 4,
  parameter int OUT_AW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic              acc_clr,
  output logic              mac_en,
  output logic              act_en,
  output logic              wr_en,
  output logic [OUT_AW-1:0] wr_addr
);

  localparam int D_W   = clog2_min1(MAC_LAT + 1);
  localparam int D_MAX = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

  state_e state_q;
  state_e state_d;

  logic              i_clr, i_inc, i_last;
  logic              j_clr, j_inc, j_last;
  logic              d_clr, d_inc, d_last;
  logic [IN_AW-1:0]  i_cnt;
  logic [OUT_AW-1:0] j_cnt;
  logic [D_W-1:0]    d_cnt;

  logic [IN_AW-1:0]  in_addr_q, in_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic [W_AW-1:0]   w_addr_cur;

  nn_index_counter #(.WIDTH(IN_AW)) u_i_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (i_clr),
    .inc   (i_inc),
    .max   (IN_AW'(N_IN - 1)),
    .cnt   (i_cnt),
    .last  (i_last)
  );

  nn_index_counter #(.WIDTH(OUT_AW)) u_j_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (j_clr),
    .inc   (j_inc),
    .max   (OUT_AW'(N_OUT - 1)),
    .cnt   (j_cnt),
    .last  (j_last)
  );

  nn_index_counter #(.WIDTH(D_W)) u_d_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (d_clr),
    .inc   (d_inc),
    .max   (D_W'(D_MAX)),
    .cnt   (d_cnt),
    .last  (d_last)
  );

  always_comb begin
    state_d = state_q;
    i_clr   = 1'b0;
    i_inc   = 1'b0;
    j_clr   = 1'b0;
    j_inc   = 1'b0;
    d_clr   = 1'b0;
    d_inc   = 1'b0;
    // Abort outranks every transition but is meaningless from IDLE.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      i_clr   = 1'b1;
      j_clr   = 1'b1;
      d_clr   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_CLEAR;
        S_CLEAR: begin
          i_clr   = 1'b1;
          state_d = S_MAC;
        end
        S_MAC: begin
          i_inc = 1'b1;
          if (i_last) state_d = (MAC_LAT > 0) ? S_DRAIN : S_ACT;
        end
        S_DRAIN: begin
          d_inc = 1'b1;
          if (d_last) state_d = S_ACT;
        end
        S_ACT:   state_d = S_WRITE;
        S_WRITE: begin
          if (j_last) begin
            state_d = S_DONE;
          end else begin
            j_inc   = 1'b1;
            state_d = S_CLEAR;
          end
        end
        S_DONE: begin
          j_clr   = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          i_clr   = 1'b1;
          j_clr   = 1'b1;
          d_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Addresses track the counters during MAC and freeze on their last value otherwise.
  assign w_addr_cur = W_AW'(j_cnt) * W_AW'(N_IN) + W_AW'(i_cnt);

  always_comb begin
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    if (state_q == S_MAC) begin
      in_addr_d = i_cnt;
      w_addr_d  = w_addr_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_addr_q <= '0;
      w_addr_q  <= '0;
    end else begin
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
    end
  end

  assign in_addr = (state_q == S_MAC) ? i_cnt : in_addr_q;
  assign w_addr  = (state_q == S_MAC) ? w_addr_cur : w_addr_q;
  assign acc_clr = (state_q == S_CLEAR);
  assign mac_en  = (state_q == S_MAC);
  assign act_en  = (state_q == S_ACT);
  assign wr_en   = (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign wr_addr = j_cnt;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer across three layer geometries:
// a timeline model queues expected strobe events, a monitor pops and compares them.
module tb_nn_layer_sequencer;

  localparam int MAXC = 2048;
  localparam int K_CLR = 0, K_MAC = 1, K_ACT = 2, K_WR = 3, K_DONE = 4;

  typedef struct {
    int cyc;
    int kind;
    int in_a;
    int w_a;
    int wr_a;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] abort_v = '0;
  int         cyc = 0;
  bit         mon_on = 1'b0;
  int         tests = 0;
  int         fails = 0;

  ev_t qa[$];
  ev_t qb[$];
  ev_t qc[$];
  bit  busy_exp [3][MAXC];

  logic       a_busy, a_done, a_acc_clr, a_mac_en, a_act_en, a_wr_en;
  logic [1:0] a_in_addr, a_wr_addr;
  logic [3:0] a_w_addr;
  logic       b_busy, b_done, b_acc_clr, b_mac_en, b_act_en, b_wr_en;
  logic [1:0] b_in_addr;
  logic [2:0] b_w_addr;
  logic       b_wr_addr;
  logic       c_busy, c_done, c_acc_clr, c_mac_en, c_act_en, c_wr_en;
  logic [1:0] c_in_addr, c_wr_addr;
  logic [3:0] c_w_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_layer_sequencer u_a (
    .clk(clk), .reset(rst), .start(start_v[0]), .abort(abort_v[0]),
    .busy(a_busy), .done(a_done), .in_addr(a_in_addr), .w_addr(a_w_addr),
    .acc_clr(a_acc_clr), .mac_en(a_mac_en), .act_en(a_act_en),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr)
  );

  nn_layer_sequencer #(
    .N_IN(3), .N_OUT(2), .MAC_LAT(2), .IN_AW(2), .W_AW(3), .OUT_AW(1)
  ) u_b (
    .clk(clk), .reset(rst), .start(start_v[1]), .abort(abort_v[1]),
    .busy(b_busy), .done(b_done), .in_addr(b_in_addr), .w_addr(b_w_addr),
    .acc_clr(b_acc_clr), .mac_en(b_mac_en), .act_en(b_act_en),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr)
  );

  nn_layer_sequencer #(
    .N_IN(4), .N_OUT(4), .MAC_LAT(0), .IN_AW(2), .W_AW(4), .OUT_AW(2)
  ) u_c (
    .clk(clk), .reset(rst), .start(start_v[2]), .abort(abort_v[2]),
    .busy(c_busy), .done(c_done), .in_addr(c_in_addr), .w_addr(c_w_addr),
    .acc_clr(c_acc_clr), .mac_en(c_mac_en), .act_en(c_act_en),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr)
  );

  function automatic int p_nin(input int w);
    return (w == 1) ? 3 : 4;
  endfunction

  function automatic int p_nout(input int w);
    return (w == 1) ? 2 : 4;
  endfunction

  function automatic int p_lat(input int w);
    return (w == 0) ? 1 : ((w == 1) ? 2 : 0);
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_CLR:   return "acc_clr";
      K_MAC:   return "mac_en";
      K_ACT:   return "act_en";
      K_WR:    return "wr_en";
      default: return "done";
    endcase
  endfunction

  function automatic int q_size(input int w);
    case (w)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic ev_t q_front(input int w);
    case (w)
      0:       return qa[0];
      1:       return qb[0];
      default: return qc[0];
    endcase
  endfunction

  task automatic q_pop(input int w, output ev_t e);
    case (w)
      0:       e = qa.pop_front();
      1:       e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
  endtask

  task automatic q_push(input int w, input int c, input int k, input int ia, input int wa,
                        input int wra, input int cut);
    ev_t e;
    if (c > cut) return;
    e.cyc = c; e.kind = k; e.in_a = ia; e.w_a = wa; e.wr_a = wra;
    case (w)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Reference timeline: a pass started at s places CLEAR at s+1 and each neuron takes
  // N_IN+MAC_LAT+3 cycles; anything after the cut cycle (abort/reset) never happens.
  task automatic plan(input int w, input int s, input int cut, output int dcyc);
    int nin, nout, lat, c;
    nin = p_nin(w); nout = p_nout(w); lat = p_lat(w);
    c = s + 1;
    for (int j = 0; j < nout; j++) begin
      q_push(w, c, K_CLR, 0, 0, 0, cut);
      for (int i = 0; i < nin; i++) q_push(w, c + 1 + i, K_MAC, i, j * nin + i, 0, cut);
      q_push(w, c + 1 + nin + lat, K_ACT, 0, 0, 0, cut);
      q_push(w, c + 2 + nin + lat, K_WR, 0, 0, j, cut);
      c += nin + lat + 3;
    end
    q_push(w, c, K_DONE, 0, 0, 0, cut);
    dcyc = c;
    for (int k = s + 1; k <= c && k <= cut && k < MAXC; k++) busy_exp[w][k] = 1'b1;
  endtask

  task automatic sample(input int w, output logic [4:0] st, output logic [31:0] ia,
                        output logic [31:0] wa, output logic [31:0] wra, output logic bsy);
    case (w)
      0: begin
        st = {a_done, a_wr_en, a_act_en, a_mac_en, a_acc_clr};
        ia = 32'(a_in_addr); wa = 32'(a_w_addr); wra = 32'(a_wr_addr); bsy = a_busy;
      end
      1: begin
        st = {b_done, b_wr_en, b_act_en, b_mac_en, b_acc_clr};
        ia = 32'(b_in_addr); wa = 32'(b_w_addr); wra = 32'(b_wr_addr); bsy = b_busy;
      end
      default: begin
        st = {c_done, c_wr_en, c_act_en, c_mac_en, c_acc_clr};
        ia = 32'(c_in_addr); wa = 32'(c_w_addr); wra = 32'(c_wr_addr); bsy = c_busy;
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input int w);
    logic [4:0]  st;
    logic [31:0] ia, wa, wra;
    logic        bsy;
    sample(w, st, ia, wa, wra, bsy);
    chk($sformatf("dut%0d reset strobes", w), 32'(st), 32'd0);
    chk($sformatf("dut%0d reset busy", w), 32'(bsy), 32'd0);
    chk($sformatf("dut%0d reset in_addr", w), ia, 32'd0);
    chk($sformatf("dut%0d reset w_addr", w), wa, 32'd0);
    chk($sformatf("dut%0d reset wr_addr", w), wra, 32'd0);
  endtask

  task automatic sb_step(input int w);
    logic [4:0]  st;
    logic [31:0] ia, wa, wra;
    logic        bsy;
    ev_t         e;
    sample(w, st, ia, wa, wra, bsy);
    while (q_size(w) > 0 && q_front(w).cyc < cyc) begin
      q_pop(w, e);
      tests++; fails++;
      $display("FAIL dut%0d missing %s: expected at cycle %0d, absent", w, kname(e.kind), e.cyc);
    end
    for (int k = 0; k < 5; k++) begin
      if (st[k] !== 1'b0) begin
        tests++;
        if (q_size(w) > 0 && q_front(w).cyc == cyc && q_front(w).kind == k) begin
          q_pop(w, e);
          if (k == K_MAC && (ia !== 32'(e.in_a) || wa !== 32'(e.w_a))) begin
            fails++;
            $display("FAIL dut%0d mac addr cycle %0d: got in=%0h w=%0h, expected in=%0h w=%0h",
                     w, cyc, ia, wa, e.in_a, e.w_a);
          end else if (k == K_WR && wra !== 32'(e.wr_a)) begin
            fails++;
            $display("FAIL dut%0d wr_addr cycle %0d: got %0h, expected %0h", w, cyc, wra, e.wr_a);
          end
        end else begin
          fails++;
          $display("FAIL dut%0d unexpected %s at cycle %0d: got %b, expected 0",
                   w, kname(k), cyc, st[k]);
        end
      end
    end
    if (cyc < MAXC) chk($sformatf("dut%0d busy", w), 32'(bsy), 32'(busy_exp[w][cyc]));
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_on) for (int w = 0; w < 3; w++) sb_step(w);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One pass: start at s, optional abort at a (-1 = none), extra start pulses p1/p2.
  task automatic run_pass(input int w, input int s, input int a, input int p1, input int p2,
                          output int e);
    int d;
    wait_until(s);
    plan(w, s, (a >= 0) ? a : MAXC, d);
    e = (a >= 0) ? a : d;
    for (int c = s; c <= e; c++) begin
      wait_until(c);
      start_v[w] = (c == s) || (c == p1) || (c == p2);
      abort_v[w] = (c == a);
    end
    wait_until(e + 1);
    start_v[w] = 1'b0;
    abort_v[w] = 1'b0;
  endtask

  task automatic random_passes(input int w, input int s0, input int n);
    int s, e, a, p, d;
    s = s0;
    for (int r = 0; r < n; r++) begin
      d = s + 1 + p_nout(w) * (p_nin(w) + p_lat(w) + 3);
      a = ($urandom_range(2, 0) == 0) ? int'($urandom_range(d, s + 1)) : -1;
      p = int'($urandom_range(d, s + 1));
      if (a >= 0 && p > a) p = a;
      run_pass(w, s, a, p, -1, e);
      s = e + 1 + int'($urandom_range(4, 0));
    end
  endtask

  initial begin
    int e, d1, d2;
    fork
      monitor();
    join_none

    wait_until(2);
    for (int w = 0; w < 3; w++) chk_zero(w);
    rst = 1'b0;
    mon_on = 1'b1;

    // Default geometry from cycle 10, with start pulses while busy and in DONE (43).
    run_pass(0, 10, -1, 25, 43, e);
    chk("pass1 done cycle", 32'(e), 32'd43);
    // Address sweep on the 3x2 layer, then the zero-latency layer.
    run_pass(1, 50, -1, -1, -1, e);
    run_pass(2, 70, -1, 80, -1, e);

    // Abort while idle must be inert.
    wait_until(101);
    abort_v[0] = 1'b1;
    wait_until(102);
    abort_v[0] = 1'b0;

    // Start held high: two passes separated by a single IDLE cycle.
    wait_until(105);
    plan(0, 105, MAXC, d1);
    plan(0, d1 + 1, MAXC, d2);
    for (int c = 105; c <= d1 + 1; c++) begin
      wait_until(c);
      start_v[0] = 1'b1;
    end
    wait_until(d1 + 2);
    start_v[0] = 1'b0;
    wait_until(d2 + 1);

    // Abort in neuron 2, MAC index 1 (CLEAR at s+17, MAC starts s+18), then a fresh pass.
    run_pass(0, 180, 199, -1, -1, e);
    run_pass(0, 205, -1, -1, -1, e);

    // Reset in the first DRAIN cycle (s+6), then idle, then a normal pass.
    wait_until(245);
    plan(0, 245, 251, d1);
    start_v[0] = 1'b1;
    wait_until(246);
    start_v[0] = 1'b0;
    wait_until(251);
    rst = 1'b1;
    wait_until(252);
    rst = 1'b0;
    chk_zero(0);
    run_pass(0, 262, -1, -1, -1, e);
    chk("post-reset done cycle", 32'(e), 32'd295);

    fork
      random_passes(0, 300, 6);
      random_passes(1, 300, 6);
      random_passes(2, 300, 6);
    join
    wait_until(cyc + 5);
    mon_on = 1'b0;

    for (int w = 0; w < 3; w++) begin
      while (q_size(w) > 0) begin
        ev_t ev;
        q_pop(w, ev);
        tests++; fails++;
        $display("FAIL dut%0d missing %s: expected at cycle %0d, absent", w, kname(ev.kind), ev.cyc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
